// File: rtl/mem_access_unit.sv
// Memory access stage: one load/store at a time on an internal word array,
// with programmable wait states, lane-aware stores and sign/zero-extended loads.
module mem_access_unit #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        req_ready,
    output logic [31:0] rdata,
    output logic        done,
    output logic        misalign_err,
    output logic [1:0]  dbg_state_o
);

    localparam int         DEPTH     = 2 ** ADDR_W;
    localparam logic [3:0] WAIT_INIT = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_ERR    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [31:0]         rdata_q;
    logic                we_q, uns_q;
    logic [1:0]          size_q;
    logic [ADDR_W+1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic [31:0]         mem [DEPTH];

    logic                accept;
    logic                misaligned;
    logic [ADDR_W-1:0]   word_idx;
    logic [1:0]          lane;
    logic [3:0]          byte_en;
    logic [31:0]         wr_lanes;
    logic [31:0]         rd_word;
    logic [7:0]          rd_byte;
    logic [15:0]         rd_half;
    logic [31:0]         load_val;

    // Handshake: a request is taken on a rising edge where req_valid && req_ready;
    // req_ready is high exactly while idle, and nothing is buffered while busy.
    assign accept     = req_valid && (state_q == S_IDLE);
    assign misaligned = (req_size == 2'b11) ||
                        ((req_size == 2'b01) && addr[0]) ||
                        ((req_size == 2'b10) && (addr[1:0] != 2'b00));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (misaligned) begin
                        state_d = S_ERR;
                    end else if (WAIT_CYCLES == 0) begin
                        state_d = S_ACCESS;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_ACCESS;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACCESS: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            S_ERR: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                err_d   = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            if (accept) begin
                we_q    <= req_we;
                uns_q   <= req_unsigned;
                size_q  <= req_size;
                addr_q  <= addr[ADDR_W+1:0];
                wdata_q <= wdata;
            end
            if ((state_q == S_ACCESS) && !we_q) begin
                rdata_q <= load_val;
            end
        end
    end

    assign word_idx = addr_q[ADDR_W+1:2];
    assign lane     = addr_q[1:0];

    // Store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        byte_en  = 4'b1111;
        wr_lanes = wdata_q;
        case (size_q)
            2'b00: begin
                byte_en  = 4'b0001 << lane;
                wr_lanes = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                byte_en  = addr_q[1] ? 4'b1100 : 4'b0011;
                wr_lanes = {2{wdata_q[15:0]}};
            end
            default: begin
                byte_en  = 4'b1111;
                wr_lanes = wdata_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if ((state_q == S_ACCESS) && we_q) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[word_idx][8*i +: 8] <= wr_lanes[8*i +: 8];
                end
            end
        end
    end

    assign rd_word = mem[word_idx];
    assign rd_byte = 8'(rd_word >> {lane, 3'b000});
    assign rd_half = addr_q[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        case (size_q)
            2'b00:   load_val = {{24{~uns_q & rd_byte[7]}}, rd_byte};
            2'b01:   load_val = {{16{~uns_q & rd_half[15]}}, rd_half};
            default: load_val = rd_word;
        endcase
    end

    assign req_ready    = (state_q == S_IDLE);
    assign rdata        = rdata_q;
    assign done         = done_q;
    assign misalign_err = err_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: two instances (2 and 0 wait states) checked every
// cycle against a byte-addressed transaction model, plus directed literal checks.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        vld [2] = '{1'b0, 1'b0};
  logic        we  [2] = '{1'b0, 1'b0};
  logic        uns [2] = '{1'b0, 1'b0};
  logic [1:0]  sz  [2] = '{2'b00, 2'b00};
  logic [31:0] ad  [2] = '{32'd0, 32'd0};
  logic [31:0] wd  [2] = '{32'd0, 32'd0};
  logic        rdy [2];
  logic        dn  [2];
  logic        er  [2];
  logic [31:0] rd  [2];
  logic [1:0]  dbg [2];

  mem_access_unit #(.ADDR_W(8), .WAIT_CYCLES(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(vld[0]), .req_we(we[0]), .req_size(sz[0]),
    .req_unsigned(uns[0]), .addr(ad[0]), .wdata(wd[0]), .req_ready(rdy[0]), .rdata(rd[0]),
    .done(dn[0]), .misalign_err(er[0]), .dbg_state_o(dbg[0])
  );

  mem_access_unit #(.ADDR_W(8), .WAIT_CYCLES(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(vld[1]), .req_we(we[1]), .req_size(sz[1]),
    .req_unsigned(uns[1]), .addr(ad[1]), .wdata(wd[1]), .req_ready(rdy[1]), .rdata(rd[1]),
    .done(dn[1]), .misalign_err(er[1]), .dbg_state_o(dbg[1])
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int wc [2] = '{2, 0};

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: byte-addressed memory + completion time
  logic [7:0]  mb [2][1024];
  bit          pend [2] = '{1'b0, 1'b0};
  int          comp [2];
  bit          p_we [2], p_uns [2], p_err [2];
  logic [1:0]  p_sz [2];
  logic [31:0] p_a [2], p_d [2];
  bit          e_rdy [2] = '{1'b1, 1'b1};
  bit          e_dn [2] = '{1'b0, 1'b0};
  bit          e_er [2] = '{1'b0, 1'b0};
  logic [31:0] e_rd [2] = '{32'd0, 32'd0};

  function automatic int nbytes(logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit misal(logic [1:0] s, logic [31:0] a);
    return (s == 2'd3) || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'd0);
  endfunction

  function automatic logic [31:0] mload(int i, logic [31:0] a, logic [1:0] s, bit u);
    int n = nbytes(s);
    int base = int'(a[9:0]);
    logic [31:0] v = 32'd0;
    for (int k = 0; k < n; k++) v = v | (32'(mb[i][(base + k) % 1024]) << (8 * k));
    if (n < 4 && !u && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic mstore(int i, logic [31:0] a, logic [1:0] s, logic [31:0] d);
    int n = nbytes(s);
    int base = int'(a[9:0]);
    for (int k = 0; k < n; k++) mb[i][(base + k) % 1024] = 8'(d >> (8 * k));
  endtask

  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        pend[i] = 1'b0; e_dn[i] = 1'b0; e_er[i] = 1'b0; e_rd[i] = 32'd0;
      end else begin
        e_dn[i] = 1'b0; e_er[i] = 1'b0;
        if (!pend[i]) begin
          if (vld[i] === 1'b1) begin
            pend[i] = 1'b1; p_we[i] = we[i]; p_uns[i] = uns[i]; p_sz[i] = sz[i];
            p_a[i] = ad[i]; p_d[i] = wd[i]; p_err[i] = misal(sz[i], ad[i]);
            comp[i] = cyc + (p_err[i] ? 1 : wc[i] + 1);
          end
        end else if (cyc == comp[i]) begin
          pend[i] = 1'b0; e_dn[i] = 1'b1; e_er[i] = p_err[i];
          if (!p_err[i]) begin
            if (p_we[i]) mstore(i, p_a[i], p_sz[i], p_d[i]);
            else e_rd[i] = mload(i, p_a[i], p_sz[i], p_uns[i]);
          end
        end
      end
      e_rdy[i] = !pend[i];
    end
    #2;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d_ready", i), 32'(rdy[i]), 32'(e_rdy[i]));
      chk($sformatf("u%0d_done", i), 32'(dn[i]), 32'(e_dn[i]));
      chk($sformatf("u%0d_err", i), 32'(er[i]), 32'(e_er[i]));
      chk($sformatf("u%0d_rdata", i), rd[i], e_rd[i]);
    end
  end

  // ---------------- driver tasks
  task automatic issue(int i, bit w, logic [1:0] s, bit u, logic [31:0] a,
                       logic [31:0] d, output int acc);
    int n = 0;
    @(negedge clk);
    while (rdy[i] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    acc = -1;
    if (n >= 50) begin
      total++; bad++;
      $display("FAIL ready_timeout: u%0d ready=%b want 1", i, rdy[i]);
      return;
    end
    vld[i] = 1'b1; we[i] = w; sz[i] = s; uns[i] = u; ad[i] = a; wd[i] = d;
    @(posedge clk);
    #1;
    vld[i] = 1'b0;
    acc = cyc;
  endtask

  task automatic wait_done(int i, output int lat, output int low);
    lat = 0;
    low = 0;
    do begin
      @(negedge clk);
      lat++;
      if (rdy[i] !== 1'b1) low++;
    end while (dn[i] !== 1'b1 && lat < 40);
    if (lat >= 40) begin
      total++; bad++;
      $display("FAIL done_timeout: u%0d done=%b want 1", i, dn[i]);
    end
  endtask

  task automatic op(int i, bit w, logic [1:0] s, bit u, logic [31:0] a,
                    logic [31:0] d, output int lat, output int low);
    int acc;
    issue(i, w, s, u, a, d, acc);
    wait_done(i, lat, low);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: sim time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus
  initial begin
    int lat, low, acc1, acc2;
    logic [1:0] s;
    logic [31:0] a;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_ready", 32'(rdy[0]), 32'd1);
    chk("rst_done", 32'(dn[0]), 32'd0);
    chk("rst_err", 32'(er[0]), 32'd0);
    chk("rst_rdata", rd[0], 32'd0);

    for (int k = 0; k < 16; k++) issue(0, 1'b1, 2'd2, 1'b0, 32'(4 * k), $urandom(), acc1);
    for (int k = 0; k < 4; k++) issue(1, 1'b1, 2'd2, 1'b0, 32'(4 * k), $urandom(), acc1);
    op(0, 1'b1, 2'd2, 1'b0, 32'h20, 32'h1122_3344, lat, low);
    op(0, 1'b1, 2'd2, 1'b0, 32'h30, 32'h1234_5678, lat, low);

    op(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, lat, low);
    op(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0, lat, low);
    chk("word_load", rd[0], 32'hDEAD_BEEF);
    chk("word_latency", 32'(lat), 32'd4);
    chk("word_busy_cycles", 32'(low), 32'd3);

    op(0, 1'b1, 2'd0, 1'b0, 32'h22, 32'h0000_00A5, lat, low);
    op(0, 1'b0, 2'd2, 1'b0, 32'h20, 32'd0, lat, low);
    chk("merge_word", rd[0], 32'h11A5_3344);
    op(0, 1'b0, 2'd0, 1'b0, 32'h22, 32'd0, lat, low);
    chk("byte_signed", rd[0], 32'hFFFF_FFA5);
    op(0, 1'b0, 2'd0, 1'b1, 32'h22, 32'd0, lat, low);
    chk("byte_unsigned", rd[0], 32'h0000_00A5);
    op(0, 1'b0, 2'd1, 1'b0, 32'h22, 32'd0, lat, low);
    chk("half_signed", rd[0], 32'h0000_11A5);

    op(0, 1'b0, 2'd2, 1'b0, 32'h21, 32'd0, lat, low);
    chk("mis_err_flag", 32'(er[0]), 32'd1);
    chk("mis_latency", 32'(lat), 32'd2);
    chk("mis_rdata_kept", rd[0], 32'h0000_11A5);
    op(0, 1'b1, 2'd1, 1'b0, 32'h23, 32'h0000_BBBB, lat, low);
    chk("mis_store_err", 32'(er[0]), 32'd1);
    op(0, 1'b0, 2'd2, 1'b0, 32'h20, 32'd0, lat, low);
    chk("mis_store_nochange", rd[0], 32'h11A5_3344);

    issue(0, 1'b1, 2'd2, 1'b0, 32'h14, 32'h0BAD_F00D, acc1);
    issue(0, 1'b0, 2'd2, 1'b0, 32'h14, 32'd0, acc2);
    chk("b2b_gap", 32'(acc2 - acc1), 32'd4);
    wait_done(0, lat, low);
    chk("b2b_load", rd[0], 32'h0BAD_F00D);

    issue(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0, acc1);
    @(negedge clk);
    vld[0] = 1'b1; we[0] = 1'b1; sz[0] = 2'd2; ad[0] = 32'h10; wd[0] = 32'd0;
    @(negedge clk);
    vld[0] = 1'b0;
    wait_done(0, lat, low);
    repeat (3) @(negedge clk);
    op(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0, lat, low);
    chk("busy_ignored", rd[0], 32'hDEAD_BEEF);

    issue(0, 1'b1, 2'd2, 1'b0, 32'h30, 32'hCAFE_F00D, acc1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(rdy[0]), 32'd1);
    chk("midrst_done", 32'(dn[0]), 32'd0);
    chk("midrst_err", 32'(er[0]), 32'd0);
    chk("midrst_rdata", rd[0], 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    op(0, 1'b0, 2'd2, 1'b0, 32'h30, 32'd0, lat, low);
    chk("midrst_nowrite", rd[0], 32'h1234_5678);

    op(1, 1'b0, 2'd2, 1'b0, 32'h4, 32'd0, lat, low);
    chk("w0_latency", 32'(lat), 32'd2);
    chk("w0_busy_cycles", 32'(low), 32'd1);
    op(1, 1'b1, 2'd2, 1'b0, 32'h000, 32'h5A5A_1234, lat, low);
    op(1, 1'b0, 2'd2, 1'b0, 32'h400, 32'd0, lat, low);
    chk("wrap_alias", rd[1], 32'h5A5A_1234);

    for (int k = 0; k < 200; k++) begin
      s = 2'($urandom_range(0, 3));
      a = ($urandom() & 32'hFFFF_FC00) | 32'($urandom_range(0, 63));
      issue(0, 1'($urandom_range(0, 1)), s, 1'($urandom_range(0, 1)), a, $urandom(), acc1);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    for (int k = 0; k < 80; k++) begin
      s = 2'($urandom_range(0, 3));
      a = ($urandom() & 32'hFFFF_FC00) | 32'($urandom_range(0, 15));
      issue(1, 1'($urandom_range(0, 1)), s, 1'($urandom_range(0, 1)), a, $urandom(), acc1);
      if ($urandom_range(0, 2) == 0) @(negedge clk);
    end
    repeat (8) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
